// File: rtl/clock_enable_pkg.sv
// Shared types and helpers for the PLL-lock qualifier and clock-enable generator.
package clock_enable_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Lock counter only needs to reach LOCK_DELAY-1; keep at least one bit.
  function automatic int lock_cnt_w(input int delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// One enable channel: period counter, shadow divisor and ce_p/ce_n decode.
module ce_divider
  import clock_enable_pkg::*;
#(
  parameter int DIVW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run_i,
  input  logic            sync_i,
  input  logic [DIVW-1:0] div_i,
  output logic            ce_p_o,
  output logic            ce_n_o
);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] shd_q, shd_d;
  logic [DIVW:0]   half;

  // Shadow follows div while idle so it holds the entry value on the first RUN
  // cycle; in RUN it only reloads at a wrap or a sync, never mid-period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    shd_d = shd_q;
    if (!run_i || sync_i || (cnt_q == shd_q)) begin
      cnt_d = '0;
      shd_d = div_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      shd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      shd_q <= shd_d;
    end
  end

  assign half   = ({1'b0, shd_q} + 1'b1) >> 1;
  assign ce_p_o = run_i && (cnt_q == '0);
  assign ce_n_o = run_i && (shd_q != '0) && ({1'b0, cnt_q} == half);

endmodule

// File: rtl/clock_enable_gen.sv
// PLL lock qualifier (sync + debounce FSM) driving a bank of phase-aligned enable dividers.
module clock_enable_gen
  import clock_enable_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DIVW       = 8,
  parameter int LOCK_DELAY = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     locked,
  input  logic [CHANNELS*DIVW-1:0] div,
  input  logic                     sync,
  output logic                     ready,
  output logic                     unlocked,
  output logic [CHANNELS-1:0]      ce_p,
  output logic [CHANNELS-1:0]      ce_n
);

  localparam int            CW   = lock_cnt_w(LOCK_DELAY);
  localparam logic [CW-1:0] LAST = CW'(LOCK_DELAY - 1);

  logic          meta_q, lsync_q;
  state_e        state_q;
  logic [CW-1:0] lcnt_q;
  logic          ready_q, unlocked_q;
  logic          run;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q     <= 1'b0;
      lsync_q    <= 1'b0;
      state_q    <= WAIT_LOCK;
      lcnt_q     <= '0;
      ready_q    <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      meta_q  <= locked;
      lsync_q <= meta_q;
      case (state_q)
        WAIT_LOCK: begin
          lcnt_q <= '0;
          if (lsync_q) state_q <= COUNT;
        end
        COUNT: begin
          if (!lsync_q) begin
            state_q <= WAIT_LOCK;
            lcnt_q  <= '0;
          end else if (lcnt_q == LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lsync_q) begin
            state_q    <= WAIT_LOCK;
            lcnt_q     <= '0;
            ready_q    <= 1'b0;
            unlocked_q <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          lcnt_q  <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign run      = (state_q == RUN);
  assign ready    = ready_q;
  assign unlocked = unlocked_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ce_divider #(.DIVW(DIVW)) u_div (
      .clock  (clock),
      .reset  (reset),
      .run_i  (run),
      .sync_i (sync),
      .div_i  (div[i*DIVW +: DIVW]),
      .ce_p_o (ce_p[i]),
      .ce_n_o (ce_n[i])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised/directed bench for clock_enable_gen against a period-level reference model.
module tb_clock_enable_gen;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int LD = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             locked = 1'b0;
  logic             sync = 1'b0;
  logic [CH*DW-1:0] div = '0;
  logic             ready, unlocked;
  logic [CH-1:0]    ce_p, ce_n;

  int total = 0;
  int bad   = 0;

  // Model state: lock streak history, and per channel the start time / length of
  // the current enable period.
  int            t;
  int            st0, st1, st2;
  bit            m_rdy, m_unl, m_run;
  int            m_start[CH], m_s[CH], m_nxt[CH];
  logic [CH-1:0] m_cp, m_cn;

  always #5 clock = ~clock;

  clock_enable_gen #(.CHANNELS(CH), .DIVW(DW), .LOCK_DELAY(LD)) dut (
    .clock    (clock),
    .reset    (reset),
    .locked   (locked),
    .div      (div),
    .sync     (sync),
    .ready    (ready),
    .unlocked (unlocked),
    .ce_p     (ce_p),
    .ce_n     (ce_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; st0 = 0; st1 = 0; st2 = 0;
    m_rdy = 0; m_unl = 0; m_run = 0;
    m_cp = '0; m_cn = '0;
  endtask

  // Ready after edge t iff locked was seen high on LD+1 consecutive edges ending at t-2.
  task automatic model_edge(input bit l, input bit s, input logic [CH*DW-1:0] d);
    int  nst;
    bit  prev;
    t++;
    nst  = l ? st0 + 1 : 0;
    st2  = st1; st1 = st0; st0 = nst;
    prev = m_rdy;
    m_rdy = (st2 >= LD + 1);
    if (prev && !m_rdy) m_unl = 1;
    for (int i = 0; i < CH; i++) begin
      if (m_rdy && (!m_run || s || t == m_nxt[i])) begin
        m_start[i] = t;
        m_s[i]     = int'(d[i*DW +: DW]);
        m_nxt[i]   = t + m_s[i] + 1;
      end
      m_cp[i] = m_rdy && (t == m_start[i]);
      m_cn[i] = m_rdy && (m_s[i] != 0) && (t == m_start[i] + (m_s[i] + 1) / 2);
    end
    m_run = m_rdy;
  endtask

  task automatic cyc(input bit l, input bit s, input logic [CH*DW-1:0] d);
    locked = l; sync = s; div = d;
    @(posedge clock);
    model_edge(l, s, d);
    @(negedge clock);
    chk("ready",    ready,    m_rdy);
    chk("unlocked", unlocked, m_unl);
    chk("ce_p",     ce_p,     m_cp);
    chk("ce_n",     ce_n,     m_cn);
  endtask

  function automatic logic [CH*DW-1:0] rnd_div();
    logic [CH*DW-1:0] d;
    for (int i = 0; i < CH; i++) d[i*DW +: DW] = DW'($urandom_range(0, 12));
    return d;
  endfunction

  initial begin
    logic [CH*DW-1:0] d0, dn;
    int               rise;
    bit               found;

    d0 = {8'd7, 8'd3, 8'd1, 8'd0};
    model_reset();

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_unl",   unlocked, 0);
    chk("rst_ce_p",  ce_p, 0);
    chk("rst_ce_n",  ce_n, 0);
    @(negedge clock);
    reset = 1'b0;

    // Lock-up: locked from edge 10, ready expected after edge 28
    rise = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(k >= 10, 1'b0, d0);
      if (ready === 1'b1 && rise == 0) begin
        rise = k;
        chk("lockup_allp", ce_p, 4'hF);
      end
    end
    chk("lockup_rise", rise, 28);

    // Lock glitch before first ready: counter restarts
    @(negedge clock); reset = 1'b1; #1; reset = 1'b0;
    model_reset();
    rise = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(k != 9, 1'b0, d0);
      if (ready === 1'b1 && rise == 0) rise = k;
    end
    chk("glitch_rise", rise, 28);
    chk("glitch_unl",  unlocked, 0);

    // Fixed divisors {7,3,1,0}
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, d0);

    // ch3 divisor 7 -> 3 when its counter is at 2
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc(1'b1, 1'b0, d0);
      if (ce_p[3] === 1'b1) found = 1;
    end
    chk("wait_ce3", found, 1);
    cyc(1'b1, 1'b0, d0);
    dn = {8'd3, 8'd3, 8'd1, 8'd0};
    for (int k = 0; k < 24; k++) cyc(1'b1, 1'b0, dn);

    // Sync at arbitrary points
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < int'($urandom_range(1, 9)); k++) cyc(1'b1, 1'b0, d0);
      cyc(1'b1, 1'b1, d0);
      chk("sync_allp", ce_p, 4'hF);
    end
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, d0);

    // Random divisors, div changes and syncs while locked
    d0 = rnd_div();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) d0 = rnd_div();
      cyc(1'b1, $urandom_range(0, 9) == 0, d0);
    end

    // Lock loss in RUN, then relock
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, d0);
    chk("loss_unl", unlocked, 1);
    chk("loss_ce",  ce_p | ce_n, 0);
    for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0, d0);
    chk("relock_rdy", ready, 1);

    // Random lock drops, syncs and divisor changes
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) d0 = rnd_div();
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 11) == 0, d0);
    end
    for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0, d0);

    // Asynchronous reset mid-RUN clears outputs immediately
    #2 reset = 1'b1;
    #1;
    chk("areset_ready", ready, 0);
    chk("areset_unl",   unlocked, 0);
    chk("areset_ce_p",  ce_p, 0);
    chk("areset_ce_n",  ce_n, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
Parametrised successor to the PLL wrapper: it qualifies the PLL `locked` signal and produces a multi-channel set of phase-aligned clock enables from the single PLL output clock. Typical use is deriving 7 MHz, 3.5 MHz, etc. enables from the 56 MHz system clock. It sits directly after the PLL, and all core logic runs on `clock` gated by these enables. It adds lock debouncing, a ready/reset release, programmable per-channel divisors, glitch-free divisor change, and a global phase-resync.

Parameters:
- CHANNELS, 4: number of enable channels.
- DIVW, 8: divisor width per channel.
- LOCK_DELAY, 1024: consecutive synchronised-locked cycles required before ready (minimum 1).

Ports:
- clock  in  1  system clock (PLL output).
- reset  in  1  asynchronous, active-high reset.
- locked  in  1  PLL lock; asynchronous to `clock`.
- div  in  CHANNELS*DIVW  per-channel divisor; channel i uses bits [i*DIVW +: DIVW].
- sync  in  1  single-cycle pulse that restarts all channel counters in phase.
- ready  out  1  high while running; core reset is ~ready.
- unlocked  out  1  sticky flag: lock was lost after ready; cleared only by reset.
- ce_p  out  CHANNELS  rising-phase enable, one cycle wide.
- ce_n  out  CHANNELS  falling-phase enable, one cycle wide.

Behaviour:
- Reset (asynchronous): sync FFs = 0, state = WAIT_LOCK, lock counter = 0, ready = 0, unlocked = 0, all channel counters and shadows = 0, ce_p = ce_n = 0.
- `locked` passes through a 2-FF synchroniser (locked_s), giving 2 cycles of latency.
- FSM transitions:
  - WAIT_LOCK: counter held at 0; locked_s = 1 -> COUNT.
  - COUNT: counter increments each cycle.
    - locked_s = 0 -> WAIT_LOCK with counter cleared.
    - counter == LOCK_DELAY-1 -> RUN.
  - RUN: ready = 1 (registered, asserted in the first RUN cycle).
    - locked_s = 0 -> WAIT_LOCK, ready = 0 the next cycle, and unlocked set to 1.
- Channel operation:
  - Counters are active only in RUN; outside RUN they are held at 0 and ce_p/ce_n = 0.
  - On entry to RUN each shadow divisor S_i is loaded from div.
  - Counter counts 0..S_i, then wraps to 0, giving a period of S_i+1 cycles.
  - ce_p[i] = RUN && cnt_i == 0.
  - ce_n[i] = RUN && S_i != 0 && cnt_i == (S_i+1)>>1.
  - S_i == 0: ce_p every cycle, ce_n never.
  - S_i == 1: ce_p and ce_n alternate.
- Divisor change: S_i reloads from div only when the counter wraps (cnt_i == S_i) or on sync. A mid-period change of div never shortens or truncates the current period.
- sync = 1 in cycle t (in RUN): every cnt_i = 0 and S_i reloaded at t+1, so all ce_p are high at t+1. sync outside RUN is ignored.
- sync coincident with a wrap: same result as sync alone.
- Loss of lock mid-period: enables stop the cycle after the FSM leaves RUN, with no partial pulse. On re-entry to RUN, channels restart phase-aligned from cnt = 0.
- Lock counter width is clog2(LOCK_DELAY); it never wraps because COUNT exits at LOCK_DELAY-1.
- Outputs ce_p, ce_n and ready are decoded from registers only, with no combinational path from inputs.

Decomposition:
- Shared package clock_enable_pkg holds:
  - the state enum {WAIT_LOCK, COUNT, RUN};
  - a localparam function for the lock counter width.
- One sub-module, ce_divider, holds per-channel counter, shadow register and ce_p/ce_n decode. Inputs: run, sync, div; outputs: ce_p, ce_n. It is instantiated CHANNELS times in a generate loop.
- The top level holds the synchroniser, FSM, lock counter and unlocked flag.

Test Plan:
- Lock-up: LOCK_DELAY=16, locked rises at cycle 10 -> ready rises at cycle 10+2+16 (±1 for edge alignment), unlocked = 0, first ce_p in every channel on that same cycle.
- Lock glitch: locked high 8 cycles, low 1 cycle, then high -> lock counter restarts; ready only after 16 further stable cycles; unlocked stays 0.
- Divisors: div = {7,3,1,0} -> ch3 ce_p every 8 cycles with ce_n at offset 4; ch2 every 4 with ce_n at offset 2; ch1 alternating ce_p/ce_n; ch0 ce_p constant, ce_n 0.
- Divisor change: ch3 div 7 -> 3 at cnt = 2 -> current period still 8 cycles, next periods 4 cycles, no extra or missing ce_p.
- Sync: sync pulse at an arbitrary cycle in RUN -> all ce_p high at the next cycle, then periods resume from 0.
- Lock loss and reset: locked drops in RUN -> ready low 3 cycles later, ce outputs 0, unlocked = 1. Relock raises ready again with unlocked still 1. Asynchronous reset mid-RUN clears all outputs immediately.
